// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one main-memory block port between the
// I-cache refill path and the D-cache refill/writeback path, one transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_mem_read,
  input  logic [ADDR_W-1:0]     i_mem_address,
  output logic [BLOCK_BITS-1:0] i_mem_readdata,
  output logic                  i_mem_busywait,
  input  logic                  d_mem_read,
  input  logic                  d_mem_write,
  input  logic [ADDR_W-1:0]     d_mem_address,
  input  logic [BLOCK_BITS-1:0] d_mem_writedata,
  output logic [BLOCK_BITS-1:0] d_mem_readdata,
  output logic                  d_mem_busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [BLOCK_BITS-1:0] mem_writedata,
  input  logic [BLOCK_BITS-1:0] mem_readdata,
  input  logic                  mem_busywait,
  output logic [1:0]            arb_owner
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state, next_state;
  logic   last_grant, next_last_grant;
  logic   seen_busy;
  logic   i_req, d_req, d_is_read;
  logic   in_busy, complete;

  assign i_req     = i_mem_read;
  assign d_req     = d_mem_read | d_mem_write;
  // A simultaneous read+write from the D-cache is treated as a writeback.
  assign d_is_read = d_mem_read & ~d_mem_write;
  assign in_busy   = (state == I_BUSY) || (state == D_BUSY);
  // Completion needs a prior busy phase, so the strobe cycle itself never completes.
  assign complete  = in_busy & seen_busy & ~mem_busywait;

  // NOTE: every signal written in this always_comb gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant == GRANT_D) begin
            next_state      = I_BUSY;
            next_last_grant = GRANT_I;
          end else begin
            next_state      = D_BUSY;
            next_last_grant = GRANT_D;
          end
        end else if (i_req) begin
          next_state      = I_BUSY;
          next_last_grant = GRANT_I;
        end else if (d_req) begin
          next_state      = D_BUSY;
          next_last_grant = GRANT_D;
        end
      end
      I_BUSY:  if (complete) next_state = I_DONE;
      D_BUSY:  if (complete) next_state = D_DONE;
      I_DONE:  next_state = IDLE;
      D_DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      last_grant     <= GRANT_I;
      seen_busy      <= 1'b0;
      i_mem_readdata <= '0;
      d_mem_readdata <= '0;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
      if (!in_busy || complete) begin
        seen_busy <= 1'b0;
      end else if (mem_busywait) begin
        seen_busy <= 1'b1;
      end
      if (complete && state == I_BUSY) begin
        i_mem_readdata <= mem_readdata;
      end
      if (complete && state == D_BUSY && d_is_read) begin
        d_mem_readdata <= mem_readdata;
      end
    end
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    arb_owner     = 2'b00;
    unique case (state)
      I_BUSY: begin
        mem_read    = i_mem_read;
        mem_address = i_mem_address;
        arb_owner   = 2'b01;
      end
      D_BUSY: begin
        mem_read      = d_is_read;
        mem_write     = d_mem_write;
        mem_address   = d_mem_address;
        mem_writedata = d_mem_writedata;
        arb_owner     = 2'b10;
      end
      I_DONE:  arb_owner = 2'b01;
      D_DONE:  arb_owner = 2'b10;
      default: arb_owner = 2'b00;
    endcase
  end

  // The busywait low cycle is exactly the DONE cycle for that side.
  assign i_mem_busywait = i_req & (state != I_DONE);
  assign d_mem_busywait = d_req & (state != D_DONE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single-requester transactions
// plus directed sequences for tie-breaking, alternation and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 28;
  localparam int BLOCK_BITS = 128;
  localparam int MEM_LAT    = 4;  // cycles the memory model holds busywait high

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  i_mem_read;
  logic [ADDR_W-1:0]     i_mem_address;
  logic [BLOCK_BITS-1:0] i_mem_readdata;
  logic                  i_mem_busywait;
  logic                  d_mem_read;
  logic                  d_mem_write;
  logic [ADDR_W-1:0]     d_mem_address;
  logic [BLOCK_BITS-1:0] d_mem_writedata;
  logic [BLOCK_BITS-1:0] d_mem_readdata;
  logic                  d_mem_busywait;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [BLOCK_BITS-1:0] mem_writedata;
  logic [BLOCK_BITS-1:0] mem_readdata;
  logic                  mem_busywait;
  logic [1:0]            arb_owner;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_BITS(BLOCK_BITS)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .i_mem_read     (i_mem_read),
    .i_mem_address  (i_mem_address),
    .i_mem_readdata (i_mem_readdata),
    .i_mem_busywait (i_mem_busywait),
    .d_mem_read     (d_mem_read),
    .d_mem_write    (d_mem_write),
    .d_mem_address  (d_mem_address),
    .d_mem_writedata(d_mem_writedata),
    .d_mem_readdata (d_mem_readdata),
    .d_mem_busywait (d_mem_busywait),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_busywait   (mem_busywait),
    .arb_owner      (arb_owner)
  );

  always #5 CLK = ~CLK;

  function automatic logic [BLOCK_BITS-1:0] pat(input logic [ADDR_W-1:0] a);
    return {4{a, 4'h0}};
  endfunction

  // Memory model: busy rises the edge after a strobe and stays high MEM_LAT cycles.
  // The cycle after busy falls is ignored so the still-held strobe is not a new access.
  logic                  m_cool;
  int                    m_cnt;
  logic                  wr_valid = 1'b0;
  logic [ADDR_W-1:0]     wr_addr  = '0;
  logic [BLOCK_BITS-1:0] wr_data  = '0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_busywait <= 1'b0;
      m_cnt        <= 0;
      m_cool       <= 1'b0;
      mem_readdata <= '0;
    end else begin
      m_cool <= 1'b0;
      if (mem_busywait) begin
        if (m_cnt == 1) begin
          mem_busywait <= 1'b0;
          m_cool       <= 1'b1;
        end
        m_cnt <= m_cnt - 1;
      end else if (!m_cool && (mem_read || mem_write)) begin
        mem_busywait <= 1'b1;
        m_cnt        <= MEM_LAT;
        if (mem_write) begin
          wr_valid <= 1'b1;
          wr_addr  <= mem_address;
          wr_data  <= mem_writedata;
        end else begin
          mem_readdata <= (wr_valid && wr_addr == mem_address) ? wr_data : pat(mem_address);
        end
      end
    end
  end

  task automatic check(input string name, input logic [BLOCK_BITS-1:0] act,
                       input logic [BLOCK_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic                  i_rd, d_rd, d_wr;
    logic [ADDR_W-1:0]     i_addr, d_addr;
    logic [BLOCK_BITS-1:0] wdata;
    logic [1:0]            owner;
    logic                  exp_rd, exp_wr;
    logic [ADDR_W-1:0]     exp_addr;
    logic [BLOCK_BITS-1:0] exp_wdata, exp_i_rdata, exp_d_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_idle();
    i_mem_read      = 1'b0;
    i_mem_address   = '0;
    d_mem_read      = 1'b0;
    d_mem_write     = 1'b0;
    d_mem_address   = '0;
    d_mem_writedata = '0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int  strobes = 0;
    bit  done = 0;
    logic bw;
    i_mem_read      = v.i_rd;
    i_mem_address   = v.i_addr;
    d_mem_read      = v.d_rd;
    d_mem_write     = v.d_wr;
    d_mem_address   = v.d_addr;
    d_mem_writedata = v.wdata;
    #1;
    bw = (v.owner == 2'b01) ? i_mem_busywait : d_mem_busywait;
    check($sformatf("row%0d busywait same cycle", idx), bw, 1'b1);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      bw = (v.owner == 2'b01) ? i_mem_busywait : d_mem_busywait;
      if (!bw) begin
        done = 1;
        check($sformatf("row%0d done owner", idx), arb_owner, v.owner);
        check($sformatf("row%0d done strobes", idx), {mem_read, mem_write}, 2'b00);
        check($sformatf("row%0d i_readdata", idx), i_mem_readdata, v.exp_i_rdata);
        check($sformatf("row%0d d_readdata", idx), d_mem_readdata, v.exp_d_rdata);
        drive_idle();
      end else if (arb_owner != 2'b00) begin
        strobes++;
        check($sformatf("row%0d owner", idx), arb_owner, v.owner);
        check($sformatf("row%0d mem_read", idx), mem_read, v.exp_rd);
        check($sformatf("row%0d mem_write", idx), mem_write, v.exp_wr);
        check($sformatf("row%0d mem_address", idx), mem_address, v.exp_addr);
        check($sformatf("row%0d mem_writedata", idx), mem_writedata, v.exp_wdata);
      end
    end
    check($sformatf("row%0d completed in budget", idx), done, 1'b1);
    // One strobe cycle before busy, MEM_LAT busy cycles, one completion cycle.
    check($sformatf("row%0d strobe cycles", idx), strobes, MEM_LAT + 2);
    @(negedge CLK);
    check($sformatf("row%0d idle after done", idx), arb_owner, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] first_owner;
    logic [1:0] prev_owner;
    logic [1:0] grants[4];
    logic [1:0] exp_grants[4];
    bit         i_done, d_done, i_bw_held, idle_ok;
    int         n_grants, idle_run;

    vecs[0] = '{1, 0, 0, 28'h10, 28'h0, '0, 2'b01, 1, 0, 28'h10, '0, pat(28'h10), '0};
    vecs[1] = '{0, 1, 0, 28'h0, 28'h35, '0, 2'b10, 1, 0, 28'h35, '0, pat(28'h10), pat(28'h35)};
    vecs[2] = '{0, 0, 1, 28'h0, 28'h22, {16{8'hA5}}, 2'b10, 0, 1, 28'h22, {16{8'hA5}},
                pat(28'h10), pat(28'h35)};
    vecs[3] = '{0, 1, 0, 28'h0, 28'h22, '0, 2'b10, 1, 0, 28'h22, '0, pat(28'h10), {16{8'hA5}}};
    vecs[4] = '{0, 1, 1, 28'h0, 28'h40, {16{8'h5A}}, 2'b10, 0, 1, 28'h40, {16{8'h5A}},
                pat(28'h10), {16{8'hA5}}};
    vecs[5] = '{1, 0, 0, 28'hFFFFFFF, 28'h0, '0, 2'b01, 1, 0, 28'hFFFFFFF, '0,
                pat(28'hFFFFFFF), {16{8'hA5}}};
    exp_grants = '{2'b10, 2'b01, 2'b10, 2'b01};

    RESET = 1'b0;
    drive_idle();
    #1;
    check("reset owner", arb_owner, 2'b00);
    check("reset strobes", {mem_read, mem_write}, 2'b00);
    check("reset busywaits", {i_mem_busywait, d_mem_busywait}, 2'b00);
    check("reset i_readdata", i_mem_readdata, '0);
    check("reset d_readdata", d_mem_readdata, '0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) run_row(i, vecs[i]);

    // Simultaneous requests after reset: D wins the first tie, I stalls throughout.
    do_reset();
    i_mem_read = 1'b1; i_mem_address = 28'h11;
    d_mem_read = 1'b1; d_mem_address = 28'h21;
    #1;
    check("tie busywaits", {i_mem_busywait, d_mem_busywait}, 2'b11);
    first_owner = 2'b00; i_done = 0; d_done = 0; i_bw_held = 1;
    for (int c = 0; c < 80 && !i_done; c++) begin
      @(negedge CLK);
      if (first_owner == 2'b00) first_owner = arb_owner;
      if (!d_done) begin
        if (!i_mem_busywait) i_bw_held = 0;
        if (!d_mem_busywait) begin
          d_done = 1;
          check("tie d done owner", arb_owner, 2'b10);
          check("tie d readdata", d_mem_readdata, pat(28'h21));
          d_mem_read = 1'b0;
        end
      end else if (!i_mem_busywait) begin
        i_done = 1;
        check("tie i done owner", arb_owner, 2'b01);
        check("tie i readdata", i_mem_readdata, pat(28'h11));
        i_mem_read = 1'b0;
      end
    end
    check("tie first owner", first_owner, 2'b10);
    check("tie i stalled during d", i_bw_held, 1'b1);
    check("tie both completed", {d_done, i_done}, 2'b11);
    @(negedge CLK);

    // Both requests held: grants alternate with exactly one IDLE cycle between them.
    i_mem_read = 1'b1; i_mem_address = 28'h12;
    d_mem_read = 1'b1; d_mem_address = 28'h23;
    prev_owner = 2'b00; n_grants = 0; idle_run = 0; idle_ok = 1;
    for (int c = 0; c < 100 && n_grants < 4; c++) begin
      @(negedge CLK);
      if (arb_owner != 2'b00 && prev_owner == 2'b00) begin
        if (n_grants > 0 && idle_run != 1) idle_ok = 0;
        grants[n_grants] = arb_owner;
        n_grants++;
      end
      idle_run   = (arb_owner == 2'b00) ? idle_run + 1 : 0;
      prev_owner = arb_owner;
    end
    check("alt grant count", n_grants, 4);
    for (int k = 0; k < 4; k++) check($sformatf("alt grant %0d", k), grants[k], exp_grants[k]);
    check("alt single idle gap", idle_ok, 1'b1);
    // Withdraw mid-transaction: the port must still finish and return to IDLE.
    repeat (3) @(negedge CLK);
    drive_idle();
    i_done = 0;
    for (int c = 0; c < 20 && !i_done; c++) begin
      @(negedge CLK);
      if (arb_owner == 2'b00) i_done = 1;
    end
    check("withdrawn txn returns idle", i_done, 1'b1);
    @(negedge CLK);
    check("withdrawn stays idle", arb_owner, 2'b00);

    // Reset two cycles into D_BUSY aborts; a held request restarts afterwards.
    d_mem_read = 1'b1; d_mem_address = 28'h33;
    d_done = 0;
    for (int c = 0; c < 10 && !d_done; c++) begin
      @(negedge CLK);
      if (arb_owner == 2'b10) d_done = 1;
    end
    check("rst d granted", d_done, 1'b1);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("rst mid owner", arb_owner, 2'b00);
    check("rst mid strobes", {mem_read, mem_write}, 2'b00);
    check("rst mid address", mem_address, '0);
    check("rst mid d busywait", d_mem_busywait, 1'b1);
    check("rst mid d readdata", d_mem_readdata, '0);
    check("rst mid i readdata", i_mem_readdata, '0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    first_owner = 2'b00; d_done = 0;
    for (int c = 0; c < 40 && !d_done; c++) begin
      @(negedge CLK);
      if (first_owner == 2'b00) first_owner = arb_owner;
      if (!d_mem_busywait) begin
        d_done = 1;
        check("rst restart readdata", d_mem_readdata, pat(28'h33));
        d_mem_read = 1'b0;
      end
    end
    check("rst restart owner", first_owner, 2'b10);
    check("rst restart completed", d_done, 1'b1);
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
